module_pipelined_cla_subtractor: RTL and testbench

//  Pipelined carry-look-ahead subtractor: diff = a - b - borrow_in, split into STAGES CLA slices.

---
 rtl/module_pipelined_cla_subtractor.sv | 131 +++++++++++++
 tb/tb_module_pipelined_cla_subtractor.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/module_pipelined_cla_subtractor.sv
// Pipelined carry-look-ahead subtractor: diff = a - b - borrow_in, one CLA slice per pipe stage.
// Optional signed overflow flag enabled by defining OVERFLOW_FLAG_EN.
module module_pipelined_cla_subtractor #(
    parameter int CLA_WIDTH = 16,
    parameter int STAGES    = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [CLA_WIDTH-1:0] a_i,
    input  logic [CLA_WIDTH-1:0] b_i,
    input  logic                 borrow_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [CLA_WIDTH-1:0] diff_o,
    output logic                 borrow_o
`ifdef OVERFLOW_FLAG_EN
    ,
    output logic                 overflow_o
`endif
);
    localparam int W   = CLA_WIDTH / STAGES;
    localparam int MSB = CLA_WIDTH - 1;

    if (CLA_WIDTH % STAGES != 0) begin : g_bad_split
        $error("CLA_WIDTH must be a multiple of STAGES");
    end

    // Pure look-ahead slice: every carry is a sum of generate/propagate products, no ripple.
    function automatic logic [W:0] cla_slice(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic cin);
        logic [W-1:0] g;
        logic [W-1:0] p;
        logic [W:0]   c;
        logic         term;
        g    = x & y;
        p    = x ^ y;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < W; i++) begin
            term = cin;
            for (int j = 0; j <= i; j++) term = term & p[j];
            c[i+1] = term;
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int m = j + 1; m <= i; m++) term = term & p[m];
                c[i+1] = c[i+1] | term;
            end
        end
        return {c[W], p ^ c[W-1:0]};
    endfunction

    logic                 adv;
    logic [STAGES-1:0]    vld_q, vld_d;
    logic [STAGES-1:0]    cy_q, cy_d;
    logic [CLA_WIDTH-1:0] diff_q [STAGES];
    logic [CLA_WIDTH-1:0] diff_d [STAGES];
    logic [CLA_WIDTH-1:0] a_q    [STAGES];
    logic [CLA_WIDTH-1:0] a_d    [STAGES];
    logic [CLA_WIDTH-1:0] bn_q   [STAGES];
    logic [CLA_WIDTH-1:0] bn_d   [STAGES];
    logic [W:0]           sl     [STAGES];

    // A single advance enable freezes every stage while the output is held.
    assign adv     = !(vld_q[STAGES-1] && !ready_i);
    assign ready_o = adv;

    always_comb begin
        // Stage 0: low slice straight from the ports; b is inverted once and skewed inverted.
        a_d[0]             = a_i;
        bn_d[0]            = ~b_i;
        vld_d[0]           = valid_i;
        sl[0]              = cla_slice(a_i[W-1:0], ~b_i[W-1:0], ~borrow_i);
        diff_d[0]          = '0;
        diff_d[0][W-1:0]   = sl[0][W-1:0];
        cy_d[0]            = sl[0][W];
        // Stage k: slice k on the registered carry and skewed operands of stage k-1.
        for (int k = 1; k < STAGES; k++) begin
            a_d[k]             = a_q[k-1];
            bn_d[k]            = bn_q[k-1];
            vld_d[k]           = vld_q[k-1];
            sl[k]              = cla_slice(a_q[k-1][k*W +: W], bn_q[k-1][k*W +: W], cy_q[k-1]);
            diff_d[k]          = diff_q[k-1];
            diff_d[k][k*W +: W] = sl[k][W-1:0];
            cy_d[k]            = sl[k][W];
        end
    end

    // A carry of 1 means "no borrow", so carries reset high to give borrow_o=0.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            vld_q <= '0;
            cy_q  <= '1;
            for (int k = 0; k < STAGES; k++) diff_q[k] <= '0;
        end else if (adv) begin
            vld_q <= vld_d;
            cy_q  <= cy_d;
            for (int k = 0; k < STAGES; k++) diff_q[k] <= diff_d[k];
        end
    end

    always_ff @(posedge clk_i) begin
        if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]  <= a_d[k];
                bn_q[k] <= bn_d[k];
            end
        end
    end

    assign valid_o  = vld_q[STAGES-1];
    assign diff_o   = diff_q[STAGES-1];
    assign borrow_o = ~cy_q[STAGES-1];

`ifdef OVERFLOW_FLAG_EN
    logic ovf_d, ovf_q;

    // Operand signs differ (a vs. non-inverted b) and the result sign left a's sign.
    assign ovf_d = (a_d[STAGES-1][MSB] == bn_d[STAGES-1][MSB]) &&
                   (diff_d[STAGES-1][MSB] != a_d[STAGES-1][MSB]);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)  ovf_q <= 1'b0;
        else if (adv)  ovf_q <= ovf_d;
    end

    assign overflow_o = ovf_q;
`endif

endmodule

// File: tb/tb_module_pipelined_cla_subtractor.sv
// Scoreboard bench for module_pipelined_cla_subtractor (optionally with OVERFLOW_FLAG_EN).
module tb_module_pipelined_cla_subtractor;
    localparam int N      = 16;
    localparam int STAGES = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         valid_i = 1'b0;
    logic         ready_i = 1'b1;
    logic         borrow_i = 1'b0;
    logic [N-1:0] a_i = '0;
    logic [N-1:0] b_i = '0;
    logic         ready_o, valid_o, borrow_o;
    logic [N-1:0] diff_o;
`ifdef OVERFLOW_FLAG_EN
    logic         overflow_o;
`endif

    typedef struct {
        logic [N-1:0] diff;
        logic         borrow;
        logic         ovf;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   n_in = 0;
    int   n_out = 0;

    always #5 clk = ~clk;

    module_pipelined_cla_subtractor #(.CLA_WIDTH(N), .STAGES(STAGES)) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .a_i        (a_i),
        .b_i        (b_i),
        .borrow_i   (borrow_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .diff_o     (diff_o),
        .borrow_o   (borrow_o)
`ifdef OVERFLOW_FLAG_EN
        ,
        .overflow_o (overflow_o)
`endif
    );

    // Reference: plain integer arithmetic on the operands.
    function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b, input logic bin);
        exp_t m;
        int   ud;
        int   sd;
        ud       = int'(a) - int'(b) - int'(bin);
        m.diff   = 16'(ud);
        m.borrow = (ud < 0);
        sd       = int'($signed(a)) - int'($signed(b)) - int'(bin);
        m.ovf    = (sd > 32767) || (sd < -32768);
        return m;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", nm, act, req);
    endtask

    // Monitor: push on input transfer, pop and compare on output transfer.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (valid_o && ready_i) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL sb_unexpected_output: actual diff %0h, required no output", diff_o);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sb_diff", 32'(diff_o), 32'(e.diff));
                    check("sb_borrow", 32'(borrow_o), 32'(e.borrow));
`ifdef OVERFLOW_FLAG_EN
                    check("sb_overflow", 32'(overflow_o), 32'(e.ovf));
`endif
                end
            end
            if (valid_i && ready_o) begin
                exp_q.push_back(model(a_i, b_i, borrow_i));
                n_in++;
            end
        end
    end

    task automatic single_op(input string nm, input logic [N-1:0] a, input logic [N-1:0] b,
                             input logic bin, input logic [N-1:0] ed, input logic eb,
                             input logic eovf);
        int cnt;
        ready_i  = 1'b1;
        a_i      = a;
        b_i      = b;
        borrow_i = bin;
        valid_i  = 1'b1;
        @(posedge clk); #1;
        valid_i  = 1'b0;
        a_i      = 16'($urandom);
        b_i      = 16'($urandom);
        cnt      = 0;
        while (!valid_o && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        check({nm, "_latency"}, 32'(cnt), 32'(STAGES - 1));
        check({nm, "_diff"}, 32'(diff_o), 32'(ed));
        check({nm, "_borrow"}, 32'(borrow_o), 32'(eb));
`ifdef OVERFLOW_FLAG_EN
        check({nm, "_overflow"}, 32'(overflow_o), 32'(eovf));
`else
        if (eovf === 1'bx) $display("unreachable");
`endif
    endtask

    task automatic drain(input string nm);
        int g;
        valid_i = 1'b0;
        ready_i = 1'b1;
        g = 0;
        while ((exp_q.size() != 0 || valid_o) && g < 50) begin
            @(posedge clk); #1;
            g++;
        end
        check({nm, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check("rst_valid_o", 32'(valid_o), 32'd0);
        check("rst_diff_o", 32'(diff_o), 32'd0);
        check("rst_borrow_o", 32'(borrow_o), 32'd0);
        check("rst_ready_o", 32'(ready_o), 32'd1);
`ifdef OVERFLOW_FLAG_EN
        check("rst_overflow_o", 32'(overflow_o), 32'd0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;

        single_op("zero_minus_borrow", 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        single_op("cross_slice", 16'h0100, 16'h0001, 1'b0, 16'h00FF, 1'b0, 1'b0);
        single_op("equal", 16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b0);
        single_op("ones_minus_zero", 16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 1'b0);
        single_op("full_chain", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        single_op("neg_overflow", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
        single_op("small_pos", 16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0);
        drain("directed");

        // Backpressure: 8 ops, ready_i low for 4 cycles after the 2nd output.
        begin
            int           sent = 0;
            int           outs = 0;
            int           stall_left = 0;
            int           guard = 0;
            logic [N:0]   held = '0;
            while (outs < 8 && guard < 200) begin
                valid_i  = (sent < 8);
                a_i      = 16'($urandom);
                b_i      = 16'($urandom);
                borrow_i = 1'($urandom_range(1));
                ready_i  = (stall_left == 0);
                @(negedge clk);
                if (stall_left > 0) begin
                    if (stall_left == 4) held = {borrow_o, diff_o};
                    check("bp_ready_o_low", 32'(ready_o), 32'd0);
                    check("bp_valid_held", 32'(valid_o), 32'd1);
                    check("bp_output_stable", 32'({borrow_o, diff_o}), 32'(held));
                    stall_left--;
                end else if (valid_o && ready_i) begin
                    outs++;
                    if (outs == 2) stall_left = 4;
                end
                if (valid_i && ready_o) sent++;
                @(posedge clk); #1;
                guard++;
            end
            check("bp_outputs", 32'(outs), 32'd8);
            drain("backpressure");
        end

        // Reset mid-stream with operations in flight.
        begin
            int seen = 0;
            ready_i = 1'b0;
            for (int i = 0; i < 3; i++) begin
                valid_i  = 1'b1;
                a_i      = 16'($urandom);
                b_i      = 16'($urandom);
                borrow_i = 1'($urandom_range(1));
                @(posedge clk); #1;
            end
            valid_i = 1'b0;
            rst_n   = 1'b0;
            #1;
            check("midrst_valid_o", 32'(valid_o), 32'd0);
            check("midrst_diff_o", 32'(diff_o), 32'd0);
            check("midrst_borrow_o", 32'(borrow_o), 32'd0);
            check("midrst_ready_o", 32'(ready_o), 32'd1);
            @(posedge clk); #1;
            rst_n   = 1'b1;
            ready_i = 1'b1;
            for (int i = 0; i < 10; i++) begin
                @(posedge clk); #1;
                if (valid_o) seen++;
            end
            check("midrst_no_emerge", 32'(seen), 32'd0);
        end

        // Random streaming, valid_i and ready_i each ~70%.
        begin
            int start_in;
            int start_out;
            int guard = 0;
            start_in  = n_in;
            start_out = n_out;
            while ((n_in - start_in) < 1000 && guard < 20000) begin
                valid_i  = ($urandom_range(99) < 70);
                a_i      = 16'($urandom);
                b_i      = 16'($urandom);
                borrow_i = 1'($urandom_range(1));
                ready_i  = ($urandom_range(99) < 70);
                @(posedge clk); #1;
                guard++;
            end
            drain("random");
            check("random_in_count", 32'(n_in - start_in), 32'd1000);
            check("random_out_count", 32'(n_out - start_out), 32'd1000);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
